clock_set_ctrl: RTL and testbench

//   Keypad-driven time-set sequencer for the 24-hour clock datapath. Walks the user

---
 rtl/clock_set_ctrl.sv | 176 +++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Keypad time-set sequencer: stages HH:MM as BCD digits, validates against 23:59, strobes load.
// Optional idle auto-abort is compiled in when CLOCK_SET_TIMEOUT_EN is defined.
module clock_set_ctrl #(
    parameter int TIMEOUT_CYC = 5000,
    parameter int CNT_W       = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       set_mode,
    output logic [1:0] digit_sel,
    output logic [3:0] hr_t,
    output logic [3:0] hr_s,
    output logic [3:0] min_t,
    output logic [3:0] min_s,
    output logic       load,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, E_HT, E_HS, E_MT, E_MS, WAIT_ENT, COMMIT} state_t;

    localparam logic [3:0] KEY_SET   = 4'hA;
    localparam logic [3:0] KEY_CLR   = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_ABORT = 4'hF;

    generate
        if ((2 ** CNT_W) <= TIMEOUT_CYC) begin : g_cnt_w_check
            $error("CNT_W too narrow for TIMEOUT_CYC");
        end
    endgenerate

    state_t     state_q, state_d;
    logic [3:0] hr_t_q, hr_t_d, hr_s_q, hr_s_d, min_t_q, min_t_d, min_s_q, min_s_d;
    logic       set_mode_q, set_mode_d, load_q, load_d, err_q, err_d;
    logic [1:0] digit_sel_q, digit_sel_d;
    logic       digit_ok;
    logic       timeout_hit;

`ifdef CLOCK_SET_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             half_q;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Counter advances on every second cycle spent waiting in an entry state.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE || state_q == COMMIT || key_valid || state_d != state_q) begin
            cnt_q  <= '0;
            half_q <= 1'b0;
        end else begin
            half_q <= ~half_q;
            if (half_q) cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        digit_ok = 1'b0;
        case (state_q)
            E_HT:    digit_ok = (key_code <= 4'd2);
            E_HS:    digit_ok = (hr_t_q == 4'd2) ? (key_code <= 4'd3) : (key_code <= 4'd9);
            E_MT:    digit_ok = (key_code <= 4'd5);
            E_MS:    digit_ok = (key_code <= 4'd9);
            default: digit_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hr_t_d  = hr_t_q;
        hr_s_d  = hr_s_q;
        min_t_d = min_t_q;
        min_s_d = min_s_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid && key_code == KEY_SET) begin
                    state_d = E_HT;
                    hr_t_d = 4'd0; hr_s_d = 4'd0; min_t_d = 4'd0; min_s_d = 4'd0;
                end
            end
            COMMIT: state_d = IDLE;
            default: begin
                if (key_valid) begin
                    if (key_code <= 4'd9) begin
                        if (digit_ok) begin
                            case (state_q)
                                E_HT:    begin hr_t_d  = key_code; state_d = E_HS;     end
                                E_HS:    begin hr_s_d  = key_code; state_d = E_MT;     end
                                E_MT:    begin min_t_d = key_code; state_d = E_MS;     end
                                default: begin min_s_d = key_code; state_d = WAIT_ENT; end
                            endcase
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (key_code)
                            KEY_SET: begin
                                state_d = E_HT;
                                hr_t_d = 4'd0; hr_s_d = 4'd0; min_t_d = 4'd0; min_s_d = 4'd0;
                            end
                            // Step back one digit and blank the digit we land on.
                            KEY_CLR: begin
                                case (state_q)
                                    E_HT:    begin hr_t_d  = 4'd0;                 end
                                    E_HS:    begin hr_t_d  = 4'd0; state_d = E_HT; end
                                    E_MT:    begin hr_s_d  = 4'd0; state_d = E_HS; end
                                    E_MS:    begin min_t_d = 4'd0; state_d = E_MT; end
                                    default: begin min_s_d = 4'd0; state_d = E_MS; end
                                endcase
                            end
                            KEY_ENTER: begin
                                if (state_q == WAIT_ENT) state_d = COMMIT;
                                else                     err_d = 1'b1;
                            end
                            KEY_ABORT: state_d = IDLE;
                            default:   err_d = 1'b1;
                        endcase
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        set_mode_d  = (state_d != IDLE);
        load_d      = (state_d == COMMIT);
        digit_sel_d = 2'd0;
        case (state_d)
            E_HS:             digit_sel_d = 2'd1;
            E_MT:             digit_sel_d = 2'd2;
            E_MS:             digit_sel_d = 2'd3;
            WAIT_ENT, COMMIT: digit_sel_d = 2'd3;
            default:          digit_sel_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hr_t_q      <= 4'd0;
            hr_s_q      <= 4'd0;
            min_t_q     <= 4'd0;
            min_s_q     <= 4'd0;
            set_mode_q  <= 1'b0;
            digit_sel_q <= 2'd0;
            load_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hr_t_q      <= hr_t_d;
            hr_s_q      <= hr_s_d;
            min_t_q     <= min_t_d;
            min_s_q     <= min_s_d;
            set_mode_q  <= set_mode_d;
            digit_sel_q <= digit_sel_d;
            load_q      <= load_d;
            err_q       <= err_d;
        end
    end

    assign set_mode  = set_mode_q;
    assign digit_sel = digit_sel_q;
    assign hr_t      = hr_t_q;
    assign hr_s      = hr_s_q;
    assign min_t     = min_t_q;
    assign min_s     = min_s_q;
    assign load      = load_q;
    assign err       = err_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: each key pushes its expected output word, popped after the edge.
// Expected word layout: {set_mode, digit_sel, hr_t, hr_s, min_t, min_s, load, err}.
module tb_clock_set_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       set_mode, load, err;
    logic [1:0] digit_sel;
    logic [3:0] hr_t, hr_s, min_t, min_s;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [20:0] exp_q[$];
    string       tag_q[$];

    localparam logic [3:0] K_SET = 4'hA, K_CLR = 4'hB, K_C = 4'hC, K_ENT = 4'hE, K_ABT = 4'hF;

    clock_set_ctrl #(.TIMEOUT_CYC(16), .CNT_W(13)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .set_mode(set_mode), .digit_sel(digit_sel),
        .hr_t(hr_t), .hr_s(hr_s), .min_t(min_t), .min_s(min_s),
        .load(load), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [20:0] pk(logic sm, logic [1:0] ds, logic [15:0] t, logic ld, logic er);
        return {sm, ds, t, ld, er};
    endfunction

    function automatic logic [20:0] obs();
        return {set_mode, digit_sel, hr_t, hr_s, min_t, min_s, load, err};
    endfunction

    task automatic check(input string tag, input logic [20:0] got, input logic [20:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s obs=%h exp=%h", tag, got, want);
        end
    endtask

    // One transaction: optional key strobe for one cycle, then compare against queued expectation.
    task automatic step(input string tag, input logic kv, input logic [3:0] k, input logic [20:0] e);
        logic [20:0] want;
        string       t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        key_valid = kv;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        $display("txn %-10s kv=%0b key=%h obs=%h", t, kv, k, obs());
        check(t, obs(), want);
    endtask

    task automatic press(input string tag, input logic [3:0] k, input logic [20:0] e);
        step(tag, 1'b1, k, e);
    endtask

    task automatic idle(input string tag, input logic [20:0] e);
        step(tag, 1'b0, 4'h0, e);
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle("reset", pk(0, 0, 16'h0000, 0, 0));

        // Reset mid-entry discards staged digits
        press("t1_set", K_SET, pk(1, 0, 16'h0000, 0, 0));
        press("t1_d1",  4'd1,  pk(1, 1, 16'h1000, 0, 0));
        press("t1_d2",  4'd2,  pk(1, 2, 16'h1200, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t1_rst", obs(), pk(0, 0, 16'h0000, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        idle("t1_post", pk(0, 0, 16'h0000, 0, 0));

        // 19:45 entry and commit; key during COMMIT ignored
        press("t2_set", K_SET, pk(1, 0, 16'h0000, 0, 0));
        press("t2_d1",  4'd1,  pk(1, 1, 16'h1000, 0, 0));
        press("t2_d9",  4'd9,  pk(1, 2, 16'h1900, 0, 0));
        press("t2_d4",  4'd4,  pk(1, 3, 16'h1940, 0, 0));
        press("t2_d5",  4'd5,  pk(1, 3, 16'h1945, 0, 0));
        press("t2_ent", K_ENT, pk(1, 3, 16'h1945, 1, 0));
        press("t2_cmt", K_SET, pk(0, 0, 16'h1945, 0, 0));
        press("t2_idl", 4'd5,  pk(0, 0, 16'h1945, 0, 0));

        // 23:59 upper bound, hour limits
        press("t3_set", K_SET, pk(1, 0, 16'h0000, 0, 0));
        press("t3_d3",  4'd3,  pk(1, 0, 16'h0000, 0, 1));
        press("t3_d2",  4'd2,  pk(1, 1, 16'h2000, 0, 0));
        press("t3_d4",  4'd4,  pk(1, 1, 16'h2000, 0, 1));
        press("t3_d3b", 4'd3,  pk(1, 2, 16'h2300, 0, 0));
        press("t3_d5",  4'd5,  pk(1, 3, 16'h2350, 0, 0));
        press("t3_d9",  4'd9,  pk(1, 3, 16'h2359, 0, 0));
        press("t3_ent", K_ENT, pk(1, 3, 16'h2359, 1, 0));
        idle("t3_done",        pk(0, 0, 16'h2359, 0, 0));

        // Minute tens limit, CLR, ABORT
        press("t4_set", K_SET, pk(1, 0, 16'h0000, 0, 0));
        press("t4_d0",  4'd0,  pk(1, 1, 16'h0000, 0, 0));
        press("t4_d7",  4'd7,  pk(1, 2, 16'h0700, 0, 0));
        press("t4_d6",  4'd6,  pk(1, 2, 16'h0700, 0, 1));
        press("t4_clr", K_CLR, pk(1, 1, 16'h0000, 0, 0));
        press("t4_abt", K_ABT, pk(0, 0, 16'h0000, 0, 0));
        idle("t4_done",        pk(0, 0, 16'h0000, 0, 0));

        // Early ENTER, code C, CLR in E_HT, restart via SET, abort holds digits
        press("t5_set", K_SET, pk(1, 0, 16'h0000, 0, 0));
        press("t5_d1",  4'd1,  pk(1, 1, 16'h1000, 0, 0));
        press("t5_d2",  4'd2,  pk(1, 2, 16'h1200, 0, 0));
        press("t5_d3",  4'd3,  pk(1, 3, 16'h1230, 0, 0));
        press("t5_ent", K_ENT, pk(1, 3, 16'h1230, 0, 1));
        press("t5_kc",  K_C,   pk(1, 3, 16'h1230, 0, 0 | 1'b1));
        press("t5_set2",K_SET, pk(1, 0, 16'h0000, 0, 0));
        press("t5_d2b", 4'd2,  pk(1, 1, 16'h2000, 0, 0));
        press("t5_clr", K_CLR, pk(1, 0, 16'h0000, 0, 0));
        press("t5_clr2",K_CLR, pk(1, 0, 16'h0000, 0, 0));
        press("t5_d1b", 4'd1,  pk(1, 1, 16'h1000, 0, 0));
        press("t5_d8",  4'd8,  pk(1, 2, 16'h1800, 0, 0));
        press("t5_abt", K_ABT, pk(0, 0, 16'h1800, 0, 0));

`ifdef CLOCK_SET_TIMEOUT_EN
        press("t6_set", K_SET, pk(1, 0, 16'h0000, 0, 0));
        press("t6_d1",  4'd1,  pk(1, 1, 16'h1000, 0, 0));
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (err || load) break;
        end
        check("t6_tmo", obs(), pk(0, 0, 16'h1000, 0, 1));
        idle("t6_done", pk(0, 0, 16'h1000, 0, 0));
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
